// File: rtl/dswb_pkg.sv
// Shared types, width helpers and saturating arithmetic for the DSWB zone
// distributor and its population counters.
package dswb_pkg;

  // state  | meaning
  // IDLE   | waiting for tick
  // SUM    | accumulate one zone demand per cycle
  // DECIDE | compare total demand against level
  // RATION | serve zones that still fit the remainder
  // APPLY  | deduct draw, pulse done
  typedef enum logic [2:0] {IDLE, SUM, DECIDE, RATION, APPLY} dist_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_v);
    return (a + b > max_v) ? max_v : a + b;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (b > a) ? 32'd0 : a - b;
  endfunction

endpackage

// File: rtl/dswb_zone_pop_counter.sv
// One saturating zone population counter; simultaneous add and subtract
// cancel out.
module dswb_zone_pop_counter
  import dswb_pkg::*;
#(
  parameter int POP_W    = 9,
  parameter int RATE_W   = 8,
  parameter int INIT_POP = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_add,
  input  logic              i_sub,
  input  logic [RATE_W-1:0] i_rate,
  output logic [POP_W-1:0]  o_pop
);

  localparam int unsigned MAX_POP = (32'd1 << POP_W) - 32'd1;

  logic [POP_W-1:0] r_pop;

  always_ff @(posedge clk) begin
    if (reset)
      r_pop <= POP_W'(INIT_POP);
    else if (i_add && !i_sub)
      r_pop <= POP_W'(sat_add(32'(r_pop), 32'(i_rate), MAX_POP));
    else if (i_sub && !i_add)
      r_pop <= POP_W'(sat_sub(32'(r_pop), 32'(i_rate)));
  end

  assign o_pop = r_pop;

endmodule

// File: rtl/dswb_zone_distributor.sv
// Multi-zone reservoir distributor: per-zone demand summed over several cycles,
// then full supply or rationing. Define DSWB_PRIORITY_ROTATE_EN for a rotating ration start.
module dswb_zone_distributor
  import dswb_pkg::*;
#(
  parameter int NUM_ZONES    = 4,
  parameter int POP_W        = 9,
  parameter int LVL_W        = 10,
  parameter int RATE_W       = 8,
  parameter int COLL_W       = 6,
  parameter int MAX_LEVEL    = 1000,
  parameter int INIT_LEVEL   = 500,
  parameter int INIT_POP     = 50,
  parameter int DEMAND_NUM   = 9,
  parameter int DEMAND_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ZONES-1:0]       pop_add,
  input  logic [NUM_ZONES-1:0]       pop_sub,
  input  logic [RATE_W-1:0]          pop_rate,
  input  logic                       rain_add,
  input  logic [COLL_W-1:0]          collect_rate,
  input  logic                       tick,
  output logic [NUM_ZONES*POP_W-1:0] zone_pop,
  output logic [LVL_W-1:0]           reservoir_level,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_ZONES-1:0]       supplied,
  output logic                       underflow,
  output logic                       overflow
);

  localparam int IDX_W  = clog2_min1(NUM_ZONES);
  localparam int DEM_W  = POP_W + 4;
  localparam int TOT_W  = DEM_W + $clog2(NUM_ZONES);
  localparam int CMP_W  = ((TOT_W > LVL_W) ? TOT_W : LVL_W) + 1;
  localparam int SUM_W  = ((LVL_W > COLL_W) ? LVL_W : COLL_W) + 2;
  localparam int PROD_W = POP_W + 16;

  dist_state_t          r_state, w_state_nxt;
  logic [POP_W-1:0]     w_pop  [NUM_ZONES];
  logic [POP_W-1:0]     r_snap [NUM_ZONES];
  logic [IDX_W-1:0]     r_idx, w_start, w_zone;
  logic [IDX_W:0]       w_rot;
  logic [DEM_W-1:0]     w_dem;
  logic [TOT_W-1:0]     r_acc;
  logic [LVL_W-1:0]     r_level, r_rem, r_draw, w_draw_apply;
  logic [SUM_W-1:0]     w_lvl_sum;
  logic [COLL_W-1:0]    w_rain;
  logic                 w_last, w_fits_all, w_fits_zone, w_clip;
  logic [NUM_ZONES-1:0] r_supplied;
  logic                 r_underflow, r_done, r_overflow;

  function automatic logic [DEM_W-1:0] demand(input logic [POP_W-1:0] p);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(p) * PROD_W'(DEMAND_NUM);
    return DEM_W'(prod >> DEMAND_SHIFT);
  endfunction

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] v);
    return (v >= (IDX_W+1)'(NUM_ZONES)) ? IDX_W'(v - (IDX_W+1)'(NUM_ZONES)) : IDX_W'(v);
  endfunction

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
    dswb_zone_pop_counter #(
      .POP_W(POP_W), .RATE_W(RATE_W), .INIT_POP(INIT_POP)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_add (pop_add[g]),
      .i_sub (pop_sub[g]),
      .i_rate(pop_rate),
      .o_pop (w_pop[g])
    );
    assign zone_pop[g*POP_W +: POP_W] = w_pop[g];
  end

  assign w_last = (r_idx == IDX_W'(NUM_ZONES - 1));

`ifdef DSWB_PRIORITY_ROTATE_EN
  logic [IDX_W-1:0] r_start;
  always_ff @(posedge clk) begin
    if (reset)
      r_start <= '0;
    else if (r_state == RATION && w_last)
      r_start <= wrap_idx((IDX_W+1)'(r_start) + (IDX_W+1)'(1));
  end
  assign w_start = r_start;
`else
  assign w_start = '0;
`endif

  assign w_rot       = (IDX_W+1)'(w_start) + (IDX_W+1)'(r_idx);
  assign w_zone      = (r_state == RATION) ? wrap_idx(w_rot) : r_idx;
  assign w_dem       = demand(r_snap[w_zone]);
  assign w_fits_all  = CMP_W'(r_level) >= CMP_W'(r_acc);
  assign w_fits_zone = CMP_W'(r_rem) >= CMP_W'(w_dem);

  // Draw comes off before rain is added, so inflow is never masked by a draw.
  assign w_rain    = rain_add ? collect_rate : '0;
  assign w_lvl_sum = SUM_W'(r_level) - SUM_W'(w_draw_apply) + SUM_W'(w_rain);
  assign w_clip    = w_lvl_sum > SUM_W'(MAX_LEVEL);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (tick)   w_state_nxt = SUM;
      SUM:     if (w_last) w_state_nxt = DECIDE;
      DECIDE:  w_state_nxt = w_fits_all ? APPLY : RATION;
      RATION:  if (w_last) w_state_nxt = APPLY;
      APPLY:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != IDLE);
    w_draw_apply = '0;
    if (r_state == APPLY) w_draw_apply = r_draw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_draw      <= '0;
      r_supplied  <= '0;
      r_underflow <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_level     <= LVL_W'(INIT_LEVEL);
      for (int i = 0; i < NUM_ZONES; i++) r_snap[i] <= '0;
    end else begin
      r_done     <= (r_state == APPLY);
      r_overflow <= w_clip;
      r_level    <= w_clip ? LVL_W'(MAX_LEVEL) : LVL_W'(w_lvl_sum);
      case (r_state)
        IDLE: if (tick) begin
          r_snap <= w_pop;
          r_acc  <= '0;
          r_idx  <= '0;
        end
        SUM: begin
          r_acc <= r_acc + TOT_W'(w_dem);
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        DECIDE: begin
          if (w_fits_all) begin
            r_supplied  <= '1;
            r_underflow <= 1'b0;
            r_draw      <= LVL_W'(r_acc);
          end else begin
            r_supplied  <= '0;
            r_underflow <= 1'b1;
            r_draw      <= '0;
            r_rem       <= r_level;
          end
        end
        RATION: begin
          // Skipped zones do not stop the scan; a smaller later zone may still fit.
          if (w_fits_zone) begin
            r_supplied[w_zone] <= 1'b1;
            r_rem              <= r_rem - LVL_W'(w_dem);
            r_draw             <= r_draw + LVL_W'(w_dem);
          end
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign reservoir_level = r_level;
  assign done            = r_done;
  assign supplied        = r_supplied;
  assign underflow       = r_underflow;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_dswb_zone_distributor.sv
// Directed bench for dswb_zone_distributor: default, low-level (100) and
// near-full (995) instances share stimulus; each phase starts from reset.
module tb_dswb_zone_distributor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pop_add, pop_sub;
  logic [7:0] pop_rate;
  logic       rain_add;
  logic [5:0] collect_rate;
  logic       tick;

  logic [35:0] d_pop, r_pop, c_pop;
  logic [9:0]  d_lvl, r_lvl, c_lvl;
  logic        d_busy, r_busy, c_busy, d_done, r_done, c_done;
  logic [3:0]  d_sup, r_sup, c_sup;
  logic        d_unf, r_unf, c_unf, d_ovf, r_ovf, c_ovf;

  int errors = 0;
  int checks = 0;
  int d_lat, r_lat, d_n, r_n;
  logic [3:0] exp_rot_sup;

  always #5 clk = ~clk;

  dswb_zone_distributor u_dut (
    .clk(clk), .reset(reset), .pop_add(pop_add), .pop_sub(pop_sub), .pop_rate(pop_rate),
    .rain_add(rain_add), .collect_rate(collect_rate), .tick(tick),
    .zone_pop(d_pop), .reservoir_level(d_lvl), .busy(d_busy), .done(d_done),
    .supplied(d_sup), .underflow(d_unf), .overflow(d_ovf));

  dswb_zone_distributor #(.INIT_LEVEL(100)) u_rat (
    .clk(clk), .reset(reset), .pop_add(pop_add), .pop_sub(pop_sub), .pop_rate(pop_rate),
    .rain_add(rain_add), .collect_rate(collect_rate), .tick(tick),
    .zone_pop(r_pop), .reservoir_level(r_lvl), .busy(r_busy), .done(r_done),
    .supplied(r_sup), .underflow(r_unf), .overflow(r_ovf));

  dswb_zone_distributor #(.INIT_LEVEL(995)) u_clip (
    .clk(clk), .reset(reset), .pop_add(pop_add), .pop_sub(pop_sub), .pop_rate(pop_rate),
    .rain_add(rain_add), .collect_rate(collect_rate), .tick(tick),
    .zone_pop(c_pop), .reservoir_level(c_lvl), .busy(c_busy), .done(c_done),
    .supplied(c_sup), .underflow(c_unf), .overflow(c_ovf));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Accept a tick, re-assert it while busy, and record done latency and count.
  task automatic run_round(output int dl, output int rl, output int dn, output int rn);
    dl = 0; rl = 0; dn = 0; rn = 0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick = (k == 2);
      step();
      if (d_done) begin dn++; if (dl == 0) dl = k; end
      if (r_done) begin rn++; if (rl == 0) rl = k; end
    end
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pop_add = '0; pop_sub = '0; pop_rate = '0;
    rain_add = 1'b0; collect_rate = '0; tick = 1'b0;
    step(); step();
    reset = 1'b0;

    chk("rst_pop",  d_pop, {9'd50, 9'd50, 9'd50, 9'd50});
    chk("rst_lvl",  d_lvl, 10'd500);
    chk("rst_busy", d_busy, 1'b0);
    chk("rst_done", d_done, 1'b0);
    chk("rst_sup",  d_sup, 4'b0000);
    chk("rst_unf",  d_unf, 1'b0);
    chk("rst_ovf",  d_ovf, 1'b0);

    // Full supply (default) and rationing (level 100) from the same tick.
    run_round(d_lat, r_lat, d_n, r_n);
    chk("full_latency", d_lat, 6);
    chk("full_done_count", d_n, 1);
    chk("full_lvl", d_lvl, 10'd276);
    chk("full_sup", d_sup, 4'b1111);
    chk("full_unf", d_unf, 1'b0);
    chk("full_busy_after", d_busy, 1'b0);
    chk("ration_latency", r_lat, 10);
    chk("ration_done_count", r_n, 1);
    chk("ration_lvl", r_lvl, 10'd44);
    chk("ration_sup", r_sup, 4'b0001);
    chk("ration_unf", r_unf, 1'b1);

    // Refill the rationed instance to 100, then ration again.
    rain_add = 1'b1; collect_rate = 6'd56;
    step();
    rain_add = 1'b0; collect_rate = '0;
    chk("refill_lvl", r_lvl, 10'd100);
`ifdef DSWB_PRIORITY_ROTATE_EN
    exp_rot_sup = 4'b0010;
`else
    exp_rot_sup = 4'b0001;
`endif
    run_round(d_lat, r_lat, d_n, r_n);
    chk("ration2_latency", r_lat, 10);
    chk("ration2_sup", r_sup, exp_rot_sup);
    chk("ration2_lvl", r_lvl, 10'd44);

    // Rain clamp at capacity.
    do_reset();
    rain_add = 1'b1; collect_rate = 6'd10;
    step();
    rain_add = 1'b0; collect_rate = '0;
    chk("clip_lvl", c_lvl, 10'd1000);
    chk("clip_ovf", c_ovf, 1'b1);
    chk("noclip_ovf", d_ovf, 1'b0);
    chk("noclip_lvl", d_lvl, 10'd510);
    step();
    chk("clip_ovf_pulse", c_ovf, 1'b0);
    chk("clip_lvl_hold", c_lvl, 10'd1000);

    // Rain in the APPLY cycle of a 224 draw from 500.
    do_reset();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("busy_after_accept", d_busy, 1'b1);
    for (int k = 1; k <= 5; k++) step();
    chk("lvl_before_apply", d_lvl, 10'd500);
    rain_add = 1'b1; collect_rate = 6'd10;
    step();
    rain_add = 1'b0; collect_rate = '0;
    chk("apply_rain_lvl", d_lvl, 10'd286);
    chk("apply_rain_done", d_done, 1'b1);
    step();
    chk("done_pulse_width", d_done, 1'b0);

    // Population saturation.
    do_reset();
    pop_rate = 8'd225; pop_add = 4'b0001;
    step(); step();
    pop_add = '0;
    chk("pop0_500", d_pop[8:0], 9'd500);
    pop_rate = 8'd40; pop_sub = 4'b0010;
    step();
    pop_sub = '0;
    chk("pop1_10", d_pop[17:9], 9'd10);
    pop_rate = 8'd20; pop_add = 4'b0001; pop_sub = 4'b0010;
    step();
    chk("pop0_sat_hi", d_pop[8:0], 9'd511);
    chk("pop1_sat_lo", d_pop[17:9], 9'd0);
    pop_add = 4'b0100; pop_sub = 4'b0100;
    step();
    pop_add = '0; pop_sub = '0;
    chk("pop2_add_sub", d_pop[26:18], 9'd50);
    chk("pop3_idle", d_pop[35:27], 9'd50);

    // Reset during SUM aborts the round.
    do_reset();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", d_busy, 1'b0);
    chk("abort_done", d_done, 1'b0);
    d_n = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (d_done) d_n++;
    end
    chk("abort_no_done", d_n, 0);
    chk("abort_lvl", d_lvl, 10'd500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
